// File: rtl/ic_pkg.sv
// Shared geometry, typedefs and refill state encoding for the icache fetch controller.
// Defaults: 64 direct-mapped lines of 16 bytes, refilled as 32-bit beats.
package ic_pkg;

    localparam int IC_LINES      = 64;
    localparam int IC_LINE_BYTES = 16;
    localparam int IC_BEATS      = IC_LINE_BYTES / 4;
    localparam int IC_OW         = $clog2(IC_BEATS);
    localparam int IC_IDXW       = $clog2(IC_LINES);
    localparam int IC_WORDW      = 25;
    localparam int IC_TAGW       = IC_WORDW - IC_IDXW - IC_OW;
    localparam int IC_LAW        = IC_WORDW - IC_OW;

    typedef logic [IC_LAW-1:0]  ic_line_addr_t;
    typedef logic [IC_TAGW-1:0] ic_tag_t;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_REQ,
        IC_FILL
    } ic_state_t;

endpackage

// File: rtl/ic_tag_ram.sv
// Direct-mapped tag store: two registered read ports, one write port, and a valid
// array with single-line clear and whole-array flush (flush has priority).
module ic_tag_ram #(
    parameter int IDXW = 6,
    parameter int TAGW = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] i_rd_idx_a,
    input  logic [IDXW-1:0] i_rd_idx_b,
    output logic [TAGW-1:0] o_rd_tag_a,
    output logic            o_rd_vld_a,
    output logic [TAGW-1:0] o_rd_tag_b,
    output logic            o_rd_vld_b,
    input  logic            i_wr_en,
    input  logic [IDXW-1:0] i_wr_idx,
    input  logic [TAGW-1:0] i_wr_tag,
    input  logic            i_clr_en,
    input  logic [IDXW-1:0] i_clr_idx,
    input  logic            i_flush
);

    localparam int LINES = 1 << IDXW;

    logic [LINES-1:0] r_valid;
    logic [TAGW-1:0]  r_tag [LINES];
    logic [TAGW-1:0]  r_rd_tag_a;
    logic [TAGW-1:0]  r_rd_tag_b;
    logic             r_rd_vld_a;
    logic             r_rd_vld_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else begin
            if (i_wr_en)
                r_valid[i_wr_idx] <= 1'b1;
            if (i_clr_en)
                r_valid[i_clr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_tag[i_wr_idx] <= i_wr_tag;
    end

    // Reads sample the arrays before this edge's write lands (read-old).
    always_ff @(posedge clk) begin
        r_rd_tag_a <= r_tag[i_rd_idx_a];
        r_rd_tag_b <= r_tag[i_rd_idx_b];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_vld_a <= 1'b0;
            r_rd_vld_b <= 1'b0;
        end else begin
            r_rd_vld_a <= r_valid[i_rd_idx_a];
            r_rd_vld_b <= r_valid[i_rd_idx_b];
        end
    end

    assign o_rd_tag_a = r_rd_tag_a;
    assign o_rd_tag_b = r_rd_tag_b;
    assign o_rd_vld_a = r_rd_vld_a;
    assign o_rd_vld_b = r_rd_vld_b;

endmodule

// File: rtl/ic_fetch_ctrl.sv
// Icache fetch responder: n1 request, n2 bank addresses, n3 per-halfword valid, single-outstanding
// line refill. Optional hit/miss counters are built when IC_PERF_CNT_EN is defined.
module ic_fetch_ctrl
    import ic_pkg::*;
#(
    parameter int LINES      = IC_LINES,
    parameter int LINE_BYTES = IC_LINE_BYTES
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [25:0]                                   fetch_addr_n1,
    input  logic                                          fetch_en_n1,
    output logic [1:0]                                    fetch_valid_n3,
    output logic                                          dm_rd_en_n2,
    output logic [$clog2(LINES*LINE_BYTES/4)-1:0]         dm_rd_addr_even_n2,
    output logic [$clog2(LINES*LINE_BYTES/4)-1:0]         dm_rd_addr_odd_n2,
    output logic                                          dm_wr_en,
    output logic [$clog2(LINES*LINE_BYTES/4)-1:0]         dm_wr_addr,
    output logic [15:0]                                   dm_wr_data_even,
    output logic [15:0]                                   dm_wr_data_odd,
    output logic                                          mem_req,
    output logic [IC_WORDW-$clog2(LINE_BYTES/4)-1:0]      mem_addr,
    input  logic                                          mem_gnt,
    input  logic                                          mem_rvalid,
    input  logic [31:0]                                   mem_rdata,
    input  logic                                          ic_flush
`ifdef IC_PERF_CNT_EN
    ,
    output logic [31:0]                                   perf_hit,
    output logic [31:0]                                   perf_miss
`endif
);

    localparam int BEATS = LINE_BYTES / 4;
    localparam int OW    = $clog2(BEATS);
    localparam int IDXW  = $clog2(LINES);
    localparam int WAW   = IDXW + OW;
    localparam int TAGW  = IC_WORDW - WAW;
    localparam int LAW   = IC_WORDW - OW;
    localparam logic [OW-1:0] BEAT_LAST = OW'(BEATS - 1);

    logic [IC_WORDW-1:0] w_word_n1;
    logic [IDXW-1:0]     w_idx_a_n1;
    logic [IDXW-1:0]     w_idx_b_n1;

    logic                r_en_n2;
    logic                r_odd_n2;
    logic [IC_WORDW-1:0] r_word_n2;
    logic [LAW-1:0]      w_line_a_n2;
    logic [LAW-1:0]      w_line_b_n2;
    logic [TAGW-1:0]     w_tag_a;
    logic [TAGW-1:0]     w_tag_b;
    logic                w_vld_a;
    logic                w_vld_b;
    logic                w_hit_a_n2;
    logic                w_hit_b_n2;

    logic                r_en_n3;
    logic                r_odd_n3;
    logic [1:0]          r_fv_n3;
    logic [LAW-1:0]      r_line_a_n3;
    logic [LAW-1:0]      r_line_b_n3;
    logic                w_miss_a;
    logic                w_miss_b;
    logic [LAW-1:0]      w_miss_line;

    ic_state_t           r_state;
    ic_state_t           w_state_nxt;
    logic [LAW-1:0]      r_line;
    logic [OW-1:0]       r_beat;
    logic                r_flush_seen;
    logic                w_req_start;
    logic                w_last_beat;
    logic                w_fill_wr;
    logic                w_tag_we;

    // n1: split the halfword address; the B port reads the line holding word+1.
    assign w_word_n1  = fetch_addr_n1[25:1];
    assign w_idx_a_n1 = w_word_n1[WAW-1:OW];
    assign w_idx_b_n1 = w_idx_a_n1 + IDXW'(&w_word_n1[OW-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en_n2   <= 1'b0;
            r_odd_n2  <= 1'b0;
            r_word_n2 <= '0;
        end else begin
            r_en_n2   <= fetch_en_n1;
            r_odd_n2  <= fetch_addr_n1[0];
            r_word_n2 <= w_word_n1;
        end
    end

    ic_tag_ram #(
        .IDXW (IDXW),
        .TAGW (TAGW)
    ) u_tag_ram (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx_a (w_idx_a_n1),
        .i_rd_idx_b (w_idx_b_n1),
        .o_rd_tag_a (w_tag_a),
        .o_rd_vld_a (w_vld_a),
        .o_rd_tag_b (w_tag_b),
        .o_rd_vld_b (w_vld_b),
        .i_wr_en    (w_tag_we),
        .i_wr_idx   (r_line[IDXW-1:0]),
        .i_wr_tag   (r_line[LAW-1:IDXW]),
        .i_clr_en   (w_req_start),
        .i_clr_idx  (w_miss_line[IDXW-1:0]),
        .i_flush    (ic_flush)
    );

    // n2: bank addresses and tag compare for word and word+1.
    assign dm_rd_en_n2        = r_en_n2;
    assign dm_rd_addr_odd_n2  = r_word_n2[WAW-1:0];
    assign dm_rd_addr_even_n2 = r_word_n2[WAW-1:0] + WAW'(r_odd_n2);

    assign w_line_a_n2 = r_word_n2[IC_WORDW-1:OW];
    assign w_line_b_n2 = w_line_a_n2 + LAW'(&r_word_n2[OW-1:0]);
    assign w_hit_a_n2  = w_vld_a & (w_tag_a == w_line_a_n2[LAW-1:IDXW]);
    assign w_hit_b_n2  = w_vld_b & (w_tag_b == w_line_b_n2[LAW-1:IDXW]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en_n3  <= 1'b0;
            r_odd_n3 <= 1'b0;
            r_fv_n3  <= 2'b00;
        end else begin
            r_en_n3  <= r_en_n2;
            r_odd_n3 <= r_odd_n2;
            if (!r_en_n2)
                r_fv_n3 <= 2'b00;
            else if (!r_odd_n2)
                r_fv_n3 <= {w_hit_a_n2, w_hit_a_n2};
            else
                r_fv_n3 <= {w_hit_b_n2, w_hit_a_n2};
        end
    end

    always_ff @(posedge clk) begin
        r_line_a_n3 <= w_line_a_n2;
        r_line_b_n3 <= w_line_b_n2;
    end

    // n3: first missing line (A before B) is offered to the refill engine.
    assign fetch_valid_n3 = r_fv_n3;
    assign w_miss_a       = r_en_n3 & ~r_fv_n3[0];
    assign w_miss_b       = r_en_n3 & r_odd_n3 & ~r_fv_n3[1];
    assign w_miss_line    = w_miss_a ? r_line_a_n3 : r_line_b_n3;

    always_comb begin
        w_state_nxt = r_state;
        w_req_start = 1'b0;
        w_last_beat = 1'b0;
        case (r_state)
            IC_IDLE: begin
                if (w_miss_a | w_miss_b) begin
                    w_state_nxt = IC_REQ;
                    w_req_start = 1'b1;
                end
            end
            IC_REQ: begin
                if (mem_gnt)
                    w_state_nxt = IC_FILL;
            end
            IC_FILL: begin
                if (mem_rvalid && (r_beat == BEAT_LAST)) begin
                    w_state_nxt = IC_IDLE;
                    w_last_beat = 1'b1;
                end
            end
            default: w_state_nxt = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IC_IDLE;
            r_line       <= '0;
            r_beat       <= '0;
            r_flush_seen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_start) begin
                r_line       <= w_miss_line;
                r_beat       <= '0;
                r_flush_seen <= 1'b0;
            end else begin
                if (w_fill_wr)
                    r_beat <= r_beat + 1'b1;
                if (ic_flush && (r_state != IC_IDLE))
                    r_flush_seen <= 1'b1;
            end
        end
    end

    // A flush seen at any point of the refill, including the last beat, keeps the line invalid.
    assign w_tag_we  = w_last_beat & ~r_flush_seen & ~ic_flush;
    assign w_fill_wr = (r_state == IC_FILL) & mem_rvalid;

    assign mem_req         = (r_state == IC_REQ);
    assign mem_addr        = r_line;
    assign dm_wr_en        = w_fill_wr;
    assign dm_wr_addr      = {r_line[IDXW-1:0], r_beat};
    assign dm_wr_data_even = w_fill_wr ? mem_rdata[15:0]  : 16'h0000;
    assign dm_wr_data_odd  = w_fill_wr ? mem_rdata[31:16] : 16'h0000;

`ifdef IC_PERF_CNT_EN
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else if (r_en_n3) begin
            if (r_fv_n3 == 2'b11) begin
                if (r_perf_hit != '1)
                    r_perf_hit <= r_perf_hit + 32'd1;
            end else begin
                if (r_perf_miss != '1)
                    r_perf_miss <= r_perf_miss + 32'd1;
            end
        end
    end

    assign perf_hit  = r_perf_hit;
    assign perf_miss = r_perf_miss;
`endif

endmodule

// File: tb/tb_ic_fetch_ctrl.sv
// Directed bench for ic_fetch_ctrl: cold miss/refill, hits, straddle, busy-drop, flush, reset mid-fill.
module tb_ic_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [25:0] fetch_addr_n1;
    logic        fetch_en_n1;
    logic [1:0]  fetch_valid_n3;
    logic        dm_rd_en_n2;
    logic [7:0]  dm_rd_addr_even_n2;
    logic [7:0]  dm_rd_addr_odd_n2;
    logic        dm_wr_en;
    logic [7:0]  dm_wr_addr;
    logic [15:0] dm_wr_data_even;
    logic [15:0] dm_wr_data_odd;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ic_flush;
`ifdef IC_PERF_CNT_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ic_fetch_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_addr_n1      (fetch_addr_n1),
        .fetch_en_n1        (fetch_en_n1),
        .fetch_valid_n3     (fetch_valid_n3),
        .dm_rd_en_n2        (dm_rd_en_n2),
        .dm_rd_addr_even_n2 (dm_rd_addr_even_n2),
        .dm_rd_addr_odd_n2  (dm_rd_addr_odd_n2),
        .dm_wr_en           (dm_wr_en),
        .dm_wr_addr         (dm_wr_addr),
        .dm_wr_data_even    (dm_wr_data_even),
        .dm_wr_data_odd     (dm_wr_data_odd),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_gnt            (mem_gnt),
        .mem_rvalid         (mem_rvalid),
        .mem_rdata          (mem_rdata),
        .ic_flush           (ic_flush)
`ifdef IC_PERF_CNT_EN
        ,
        .perf_hit           (perf_hit),
        .perf_miss          (perf_miss)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Byte address in; checks n2 bank addresses one cycle later and n3 valid two cycles later.
    task automatic fetch(input logic [31:0] baddr, input logic [1:0] exp_v,
                         input logic [7:0] exp_even, input logic [7:0] exp_odd);
        fetch_addr_n1 = baddr[26:1];
        fetch_en_n1   = 1'b1;
        tick;
        fetch_en_n1   = 1'b0;
        chk("rd_en_n2", 32'(dm_rd_en_n2), 32'd1);
        chk("rd_even", 32'(dm_rd_addr_even_n2), 32'(exp_even));
        chk("rd_odd", 32'(dm_rd_addr_odd_n2), 32'(exp_odd));
        tick;
        chk("valid_n3", 32'(fetch_valid_n3), 32'(exp_v));
    endtask

    task automatic req_grant(input logic [22:0] line);
        for (int i = 0; i < 10 && !mem_req; i++)
            tick;
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_addr", 32'(mem_addr), 32'(line));
        mem_gnt = 1'b1;
        tick;
        mem_gnt = 1'b0;
    endtask

    task automatic beats(input logic [22:0] line, input int b0, input int b1);
        logic [31:0] d;
        for (int b = b0; b <= b1; b++) begin
            d          = $urandom;
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            #1;
            chk("wr_en", 32'(dm_wr_en), 32'd1);
            chk("wr_addr", 32'(dm_wr_addr), 32'({line[5:0], 2'(b)}));
            chk("wr_even", 32'(dm_wr_data_even), 32'(d[15:0]));
            chk("wr_odd", 32'(dm_wr_data_odd), 32'(d[31:16]));
            tick;
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        fetch_addr_n1 = '0;
        fetch_en_n1   = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        ic_flush      = 1'b0;
        tick;
        tick;
        tick;
        chk("rst_valid", 32'(fetch_valid_n3), 32'd0);
        chk("rst_rd_en", 32'(dm_rd_en_n2), 32'd0);
        chk("rst_wr_en", 32'(dm_wr_en), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rd_even", 32'(dm_rd_addr_even_n2), 32'd0);
        rst_n = 1'b1;
        tick;

        // Cold miss, refill of line 0x10, then hit.
        fetch(32'h100, 2'b00, 8'h40, 8'h40);
        req_grant(23'h10);
        beats(23'h10, 0, 3);
        tick;
        fetch(32'h100, 2'b11, 8'h40, 8'h40);

        // Odd halfword mid-line.
        fetch(32'h106, 2'b11, 8'h42, 8'h41);

        // Straddle into uncached next line, then refill it.
        fetch(32'h10E, 2'b01, 8'h44, 8'h43);
        req_grant(23'h11);
        beats(23'h11, 0, 3);
        tick;
        fetch(32'h10E, 2'b11, 8'h44, 8'h43);

        // Second miss while filling is dropped; retry after idle.
        fetch(32'h200, 2'b00, 8'h80, 8'h80);
        req_grant(23'h20);
        beats(23'h20, 0, 0);
        fetch(32'h300, 2'b00, 8'hC0, 8'hC0);
        tick;
        chk("busy_no_req", 32'(mem_req), 32'd0);
        beats(23'h20, 1, 3);
        tick;
        chk("idle_no_req", 32'(mem_req), 32'd0);
        fetch(32'h300, 2'b00, 8'hC0, 8'hC0);
        req_grant(23'h30);
        beats(23'h30, 0, 3);
        tick;
        fetch(32'h300, 2'b11, 8'hC0, 8'hC0);
        fetch(32'h200, 2'b11, 8'h80, 8'h80);

        // Flush during a fill: filled line and earlier lines all miss.
        fetch(32'h400, 2'b00, 8'h00, 8'h00);
        req_grant(23'h40);
        beats(23'h40, 0, 1);
        ic_flush = 1'b1;
        tick;
        ic_flush = 1'b0;
        beats(23'h40, 2, 3);
        tick;
        fetch(32'h400, 2'b00, 8'h00, 8'h00);
        fetch(32'h100, 2'b00, 8'h40, 8'h40);

        // Reset in the middle of a fill with beats still arriving.
        req_grant(23'h40);
        beats(23'h40, 0, 1);
        rst_n      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        tick;
        chk("rstf_wr_en", 32'(dm_wr_en), 32'd0);
        chk("rstf_mem_req", 32'(mem_req), 32'd0);
        chk("rstf_mem_addr", 32'(mem_addr), 32'd0);
        chk("rstf_wr_addr", 32'(dm_wr_addr), 32'd0);
        chk("rstf_wr_even", 32'(dm_wr_data_even), 32'd0);
        chk("rstf_valid", 32'(fetch_valid_n3), 32'd0);
        chk("rstf_rd_en", 32'(dm_rd_en_n2), 32'd0);
        rst_n = 1'b1;
        tick;
        chk("rstf_beat_ign", 32'(dm_wr_en), 32'd0);
        mem_rvalid = 1'b0;
        fetch(32'h300, 2'b00, 8'hC0, 8'hC0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
